// File: rtl/cnx_pkg.sv
// cnx_pkg: lane count and lane-slice helper shared by the combining network.
package cnx_pkg;

    localparam int LANES = 8;

    function automatic int lane_off(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/cnx_delay_line.sv
// cnx_delay_line: resettable register delay line of configurable width and depth.
module cnx_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        assign q = d;
    end else begin : g_pipe
        logic [W-1:0] stage_d [DEPTH];
        logic [W-1:0] stage_q [DEPTH];
        always_comb begin
            stage_d[0] = d;
            for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end
        assign q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/cnx8_combiner.sv
// cnx8_combiner: merges valid lanes sharing a destination id into the lowest-index lane,
// summing their updates; fixed PIPE_DEPTH latency, one vector per cycle.
module cnx8_combiner
    import cnx_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PIPE_DEPTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        InputValid,
    input  logic [LANES*DATA_W-1:0] InDestVid,
    input  logic [LANES*DATA_W-1:0] InUpdate,
    output logic [LANES*DATA_W-1:0] OutUpdate,
    output logic [LANES*DATA_W-1:0] OutDestVid,
    output logic [LANES-1:0]        OutValid
);

    localparam int BUS_W = LANES + 2 * LANES * DATA_W;

    logic [LANES-1:0][LANES-1:0] eq_d, eq_q;
    logic [LANES-1:0]            vld_d, vld_q;
    logic [LANES*DATA_W-1:0]     vid_d, vid_q;
    logic [LANES*DATA_W-1:0]     upd_d, upd_q;
    logic [LANES-1:0]            lead_d, lead_q;
    logic [LANES*DATA_W-1:0]     oid_d, oid_q;
    logic [LANES*DATA_W-1:0]     osum_d, osum_q;
    logic [BUS_W-1:0]            out_bus;

    always_comb begin
        vld_d = InputValid;
        vid_d = InDestVid;
        upd_d = InUpdate;
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < LANES; j++) begin
                eq_d[i][j] = InputValid[i] & InputValid[j] &
                    (InDestVid[lane_off(i, DATA_W) +: DATA_W] == InDestVid[lane_off(j, DATA_W) +: DATA_W]);
            end
        end
    end

    // eq_q[i][i] equals the lane's valid, so each lane's own update is included in its sum
    always_comb begin
        lead_d = '0;
        oid_d  = '0;
        osum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            lead_d[i] = vld_q[i];
            for (int j = 0; j < i; j++) lead_d[i] = lead_d[i] & ~eq_q[i][j];
            for (int j = 0; j < LANES; j++) begin
                osum_d[lane_off(i, DATA_W) +: DATA_W] = osum_d[lane_off(i, DATA_W) +: DATA_W] +
                    (eq_q[i][j] ? upd_q[lane_off(j, DATA_W) +: DATA_W] : '0);
            end
            osum_d[lane_off(i, DATA_W) +: DATA_W] = lead_d[i] ? osum_d[lane_off(i, DATA_W) +: DATA_W] : '0;
            oid_d[lane_off(i, DATA_W) +: DATA_W]  = lead_d[i] ? vid_q[lane_off(i, DATA_W) +: DATA_W] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eq_q   <= '0;
            vld_q  <= '0;
            vid_q  <= '0;
            upd_q  <= '0;
            lead_q <= '0;
            oid_q  <= '0;
            osum_q <= '0;
        end else begin
            eq_q   <= eq_d;
            vld_q  <= vld_d;
            vid_q  <= vid_d;
            upd_q  <= upd_d;
            lead_q <= lead_d;
            oid_q  <= oid_d;
            osum_q <= osum_d;
        end
    end

    cnx_delay_line #(
        .W     (BUS_W),
        .DEPTH (PIPE_DEPTH - 2)
    ) u_pad (
        .clk (clk),
        .rst (rst),
        .d   ({lead_q, oid_q, osum_q}),
        .q   (out_bus)
    );

    assign {OutValid, OutDestVid, OutUpdate} = out_bus;

endmodule

// File: tb/tb_cnx8_combiner.sv
// tb_cnx8_combiner: directed vectors with hand-computed results for the 8-lane combiner.
module tb_cnx8_combiner;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   InputValid;
    logic [255:0] InDestVid;
    logic [255:0] InUpdate;
    logic [255:0] OutUpdate;
    logic [255:0] OutDestVid;
    logic [7:0]   OutValid;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ids [8];
    logic [31:0] ups [8];
    logic [31:0] eid [8];
    logic [31:0] eup [8];

    cnx8_combiner #(.DATA_W(32), .PIPE_DEPTH(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .InputValid (InputValid),
        .InDestVid  (InDestVid),
        .InUpdate   (InUpdate),
        .OutUpdate  (OutUpdate),
        .OutDestVid (OutDestVid),
        .OutValid   (OutValid)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] pack8(input logic [31:0] a [8]);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = a[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [7:0] v);
        InputValid = v;
        InDestVid  = pack8(ids);
        InUpdate   = pack8(ups);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 8; i++) begin
            eid[i] = '0;
            eup[i] = '0;
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] v);
        chk({tag, "_valid"}, {248'b0, OutValid}, {248'b0, v});
        chk({tag, "_id"}, OutDestVid, pack8(eid));
        chk({tag, "_upd"}, OutUpdate, pack8(eup));
    endtask

    task automatic expect_idle(input string tag);
        chk(tag, {248'b0, OutValid}, 256'b0);
    endtask

    initial begin
        rst        = 1'b1;
        InputValid = 'x;
        InDestVid  = 'x;
        InUpdate   = 'x;
        clear_exp();
        for (int c = 0; c < 4; c++) begin
            tick();
            expect_out("reset", 8'h00);
        end
        rst        = 1'b0;
        InputValid = 8'h00;
        InDestVid  = '0;
        InUpdate   = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            expect_idle("post_reset_idle");
        end

        // distinct ids followed immediately by the duplicate vector
        for (int i = 0; i < 8; i++) begin
            ids[i] = 32'(8 - i);
            ups[i] = 32'd1;
        end
        apply(8'hFF);
        tick();
        ids = '{32'd1, 32'd5, 32'd1, 32'd5, 32'd5, 32'd2, 32'd2, 32'd2};
        for (int i = 0; i < 8; i++) ups[i] = 32'd1;
        apply(8'hFF);
        tick();
        InputValid = 8'h00;
        tick();
        tick();
        expect_idle("latency_early");
        tick();
        for (int i = 0; i < 8; i++) begin
            eid[i] = 32'(8 - i);
            eup[i] = 32'd1;
        end
        expect_out("distinct", 8'hFF);
        tick();
        clear_exp();
        eid[0] = 32'd1; eup[0] = 32'd2;
        eid[1] = 32'd5; eup[1] = 32'd3;
        eid[5] = 32'd2; eup[5] = 32'd3;
        expect_out("dups", 8'b0010_0011);
        tick();
        expect_idle("after_dups");

        // invalid lanes do not join the group
        for (int i = 0; i < 8; i++) begin
            ids[i] = 32'd7;
            ups[i] = 32'd10;
        end
        apply(8'b1010_0100);
        tick();
        InputValid = 8'h00;
        for (int c = 0; c < 4; c++) tick();
        clear_exp();
        eid[2] = 32'd7; eup[2] = 32'd30;
        expect_out("invalid_lanes", 8'b0000_0100);

        // wraparound on summation
        for (int i = 0; i < 8; i++) begin
            ids[i] = 32'd0;
            ups[i] = 32'd0;
        end
        ids[0] = 32'd9; ups[0] = 32'hFFFF_FFFF;
        ids[1] = 32'd9; ups[1] = 32'd2;
        apply(8'b0000_0011);
        tick();
        InputValid = 8'h00;
        for (int c = 0; c < 4; c++) tick();
        clear_exp();
        eid[0] = 32'd9; eup[0] = 32'd1;
        expect_out("overflow", 8'b0000_0001);

        // reset while three vectors are in flight
        for (int i = 0; i < 8; i++) begin
            ids[i] = 32'(i + 20);
            ups[i] = 32'(i + 1);
        end
        for (int c = 0; c < 3; c++) begin
            apply(8'hFF);
            tick();
        end
        InputValid = 8'h00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            expect_idle("midreset_flush");
        end

        // operation resumes after the flush
        apply(8'h81);
        tick();
        InputValid = 8'h00;
        for (int c = 0; c < 4; c++) tick();
        clear_exp();
        eid[0] = 32'd20; eup[0] = 32'd1;
        eid[7] = 32'd27; eup[7] = 32'd8;
        expect_out("resume", 8'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
